// File: rtl/alu_pkg.sv
// Shared op encodings and FSM state type for the EX-stage ALU with iterative multiply/divide.
package alu_pkg;

    typedef enum logic [4:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLL    = 5'd2,
        OP_SLT    = 5'd3,
        OP_SLTU   = 5'd4,
        OP_XOR    = 5'd5,
        OP_SRL    = 5'd6,
        OP_SRA    = 5'd7,
        OP_OR     = 5'd8,
        OP_AND    = 5'd9,
        OP_PASSB  = 5'd10,
        OP_LINK   = 5'd11,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        DONE = 2'd3
    } mdu_state_e;

    localparam logic [4:0] OP_MDU_BASE = 5'd16;

endpackage

// File: rtl/mdu_iter.sv
// Iterative unsigned datapath: one bit per cycle of shift-add multiply or restoring divide.
// lo/hi hold multiplier->product-low / dividend->quotient and partial-product-high / remainder.
module mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            div_sel,
    input  logic            run,
    input  logic [XLEN-1:0] opa,
    input  logic [XLEN-1:0] opb,
    output logic            done,
    output logic [XLEN-1:0] lo_nxt,
    output logic [XLEN-1:0] hi_nxt
);
    localparam int CNT_W = $clog2(XLEN);

    logic [CNT_W-1:0] cnt;
    logic [XLEN-1:0]  lo, hi, b_q;
    logic             div_q;
    logic [XLEN:0]    sum, sh, diff;
    logic             ge;

    // Outputs are the values after this cycle's step so the last step's result is usable at done.
    always_comb begin
        sum  = {1'b0, hi} + (lo[0] ? {1'b0, b_q} : '0);
        sh   = {hi, lo[XLEN-1]};
        diff = sh - {1'b0, b_q};
        ge   = !diff[XLEN];
        if (div_q) begin
            hi_nxt = ge ? diff[XLEN-1:0] : sh[XLEN-1:0];
            lo_nxt = {lo[XLEN-2:0], ge};
        end else begin
            {hi_nxt, lo_nxt} = {sum, lo[XLEN-1:1]};
        end
    end

    assign done = run && (cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            lo    <= '0;
            hi    <= '0;
            b_q   <= '0;
            div_q <= 1'b0;
        end else if (start) begin
            cnt   <= '0;
            lo    <= opa;
            hi    <= '0;
            b_q   <= opb;
            div_q <= div_sel;
        end else if (run) begin
            cnt <= cnt + 1'b1;
            lo  <= lo_nxt;
            hi  <= hi_nxt;
        end
    end

endmodule

// File: rtl/alu_mdu.sv
// RV32I ALU plus RV32M multiply/divide with valid/ready handshake; base ops take one cycle,
// MUL*/DIV*/REM* run XLEN cycles through mdu_iter on operand magnitudes.
module alu_mdu
    import alu_pkg::*;
#(
    parameter  int XLEN    = 32,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [4:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic [XLEN-1:0] pcadd4_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] result_o,
    output logic            busy_o
);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    mdu_state_e        state, state_nxt, launch_state;
    logic              accept, is_mdu, is_mul, is_div, is_rem, div_zero, div_ovf, early;
    logic              a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag, base_res, one_res, post_res;
    logic [SHAMT_W-1:0] shamt;
    logic [4:0]        op_q;
    logic              neg_q, aneg_q;
    logic              it_start, it_done;
    logic [XLEN-1:0]   it_lo, it_hi, quot_s, rem_s;
    logic [2*XLEN-1:0] prod_s;

    assign shamt    = b_i[SHAMT_W-1:0];
    assign accept   = in_valid_i && in_ready_o && !flush_i;
    assign is_mdu   = (op_i[4:3] == 2'b10);
    assign is_mul   = is_mdu && !op_i[2];
    assign is_div   = is_mdu && op_i[2];
    assign is_rem   = op_i[1];
    assign div_zero = (b_i == '0);
    assign div_ovf  = (op_i == OP_DIV || op_i == OP_REM) && (a_i == SMIN) && (b_i == '1);
    assign early    = is_div && (div_zero || div_ovf);

    assign a_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_MULHSU) ||
                   (op_i == OP_DIV) || (op_i == OP_REM);
    assign b_sgn = (op_i == OP_MUL) || (op_i == OP_MULH) || (op_i == OP_DIV) || (op_i == OP_REM);
    assign a_neg = a_sgn && a_i[XLEN-1];
    assign b_neg = b_sgn && b_i[XLEN-1];
    assign a_mag = a_neg ? -a_i : a_i;
    assign b_mag = b_neg ? -b_i : b_i;

    always_comb begin
        base_res = '0;
        case (op_i)
            OP_ADD:   base_res = a_i + b_i;
            OP_SUB:   base_res = a_i - b_i;
            OP_SLL:   base_res = a_i << shamt;
            OP_SLT:   base_res = {{(XLEN-1){1'b0}}, $signed(a_i) < $signed(b_i)};
            OP_SLTU:  base_res = {{(XLEN-1){1'b0}}, a_i < b_i};
            OP_XOR:   base_res = a_i ^ b_i;
            OP_SRL:   base_res = a_i >> shamt;
            OP_SRA:   base_res = XLEN'($signed(a_i) >>> shamt);
            OP_OR:    base_res = a_i | b_i;
            OP_AND:   base_res = a_i & b_i;
            OP_PASSB: base_res = b_i;
            OP_LINK:  base_res = pcadd4_i;
            default:  base_res = '0;
        endcase
    end

    // Divide early-outs follow RISC-V: x/0 -> all ones, rem a; MIN/-1 -> MIN, rem 0.
    always_comb begin
        one_res = base_res;
        if (is_div) begin
            if (div_zero) one_res = is_rem ? a_i : '1;
            else          one_res = is_rem ? '0 : a_i;
        end
    end

    always_comb begin
        if (is_mul)                launch_state = MUL;
        else if (is_div && !early) launch_state = DIV;
        else                       launch_state = DONE;
    end

    assign it_start = accept && (launch_state != DONE);

    mdu_iter #(.XLEN(XLEN)) u_iter (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (it_start),
        .div_sel(is_div),
        .run    (busy_o),
        .opa    (a_mag),
        .opb    (b_mag),
        .done   (it_done),
        .lo_nxt (it_lo),
        .hi_nxt (it_hi)
    );

    always_comb begin
        prod_s = neg_q ? -{it_hi, it_lo} : {it_hi, it_lo};
        quot_s = neg_q ? -it_lo : it_lo;
        rem_s  = aneg_q ? -it_hi : it_hi;
        case (op_q)
            OP_MUL:                        post_res = prod_s[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  post_res = prod_s[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               post_res = quot_s;
            default:                       post_res = rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush_i) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (accept) state_nxt = launch_state;
                DONE:    if (accept) state_nxt = launch_state;
                         else if (out_ready_i) state_nxt = IDLE;
                default: if (it_done) state_nxt = DONE;
            endcase
        end
    end

    // A held result that is being consumed this cycle frees the block for a new op.
    always_comb begin
        out_valid_o = (state == DONE);
        busy_o      = (state == MUL) || (state == DIV);
        in_ready_o  = (state == IDLE) || ((state == DONE) && out_ready_i);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result_o <= '0;
            op_q     <= '0;
            neg_q    <= 1'b0;
            aneg_q   <= 1'b0;
        end else if (accept) begin
            op_q   <= op_i;
            neg_q  <= a_neg ^ b_neg;
            aneg_q <= a_neg;
            if (launch_state == DONE) result_o <= one_res;
        end else if (it_done && !flush_i) begin
            result_o <= post_res;
        end
    end

endmodule

// File: tb/tb_alu_mdu.sv
// Scoreboard bench for alu_mdu: directed ops push expected results, a negedge monitor checks them.
module tb_alu_mdu;
    import alu_pkg::*;

    logic        clk = 1'b0, rst_n = 1'b1, flush_i = 1'b0, in_valid_i = 1'b0, out_ready_i = 1'b1;
    logic [4:0]  op_i = '0;
    logic [31:0] a_i = '0, b_i = '0, pcadd4_i = 32'h0000_1004;
    logic        in_ready_o, out_valid_o, busy_o;
    logic [31:0] result_o;

    alu_mdu #(.XLEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush_i(flush_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .op_i(op_i), .a_i(a_i), .b_i(b_i), .pcadd4_i(pcadd4_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .result_o(result_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       nm;
        logic [31:0] res;
        int          lat;
        int          acc;
    } exp_t;
    exp_t sb[$];

    int tests = 0, fails = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Monitor: latency on first valid, stability while stalled, value on handshake.
    logic        seen = 1'b0, hold = 1'b0;
    logic [31:0] held = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
            hold = 1'b0;
        end else if (out_valid_o) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL spurious_valid: got out_valid=1 result=%h expected no output", result_o);
            end else begin
                if (hold) chk({"hold_", sb[0].nm}, result_o, held);
                if (!seen && sb[0].lat != 0)
                    chk({"latency_", sb[0].nm}, 32'(cyc - sb[0].acc + 1), 32'(sb[0].lat));
                seen = 1'b1;
                if (out_ready_i) begin
                    chk(sb[0].nm, result_o, sb[0].res);
                    void'(sb.pop_front());
                    seen = 1'b0;
                    hold = 1'b0;
                end else begin
                    hold = 1'b1;
                    held = result_o;
                end
            end
        end else begin
            hold = 1'b0;
        end
    end

    task automatic push_exp(input string nm, input logic [31:0] exp, input int lat);
        exp_t e;
        e.nm  = nm;
        e.res = exp;
        e.lat = lat;
        e.acc = cyc + 1;
        sb.push_back(e);
    endtask

    task automatic send(input string nm, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat,
                        input bit push = 1'b1);
        int n = 0;
        @(posedge clk); #1;
        in_valid_i = 1'b1; op_i = op; a_i = a; b_i = b;
        forever begin
            @(negedge clk);
            if (in_ready_o) begin
                if (push) push_exp(nm, exp, lat);
                break;
            end
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL accept_timeout_%s: got in_ready=0 expected 1 within 200 cycles", nm);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid_i = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_queue_empty", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid_o), 32'd0);
        chk("rst_result", result_o, 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_in_ready", 32'(in_ready_o), 32'd1);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send("add_ovf",  OP_ADD,   32'h7FFF_FFFF, 32'd1,         32'h8000_0000, 1);
        send("sub",      OP_SUB,   32'd5,         32'd7,         32'hFFFF_FFFE, 1);
        send("sll_mask", OP_SLL,   32'd1,         32'h0000_003F, 32'h8000_0000, 1);
        send("slt",      OP_SLT,   32'hFFFF_FFFF, 32'd1,         32'd1,         1);
        send("sltu",     OP_SLTU,  32'hFFFF_FFFF, 32'd1,         32'd0,         1);
        send("xor",      OP_XOR,   32'hF0F0_F0F0, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
        send("srl",      OP_SRL,   32'h8000_0000, 32'd4,         32'h0800_0000, 1);
        send("sra",      OP_SRA,   32'h8000_0000, 32'd4,         32'hF800_0000, 1);
        send("or",       OP_OR,    32'h0000_000F, 32'h0000_00F0, 32'h0000_00FF, 1);
        send("and",      OP_AND,   32'h0000_000F, 32'h0000_00FC, 32'h0000_000C, 1);
        send("passb",    OP_PASSB, 32'hDEAD_BEEF, 32'h0000_1234, 32'h0000_1234, 1);
        send("link",     OP_LINK,  32'hDEAD_BEEF, 32'h0000_5555, 32'h0000_1004, 1);
        send("rsv13",    5'd13,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);
        send("rsv27",    5'd27,    32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0,         1);

        send("mulh",     OP_MULH,  32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 33);
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (busy_o) cnt++;
        end
        chk("mulh_busy_cycles", 32'(cnt), 32'd32);

        send("mul",      OP_MUL,    32'd3,         32'hFFFF_FFFB, 32'hFFFF_FFF1, 33);
        send("mulhu",    OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        send("mulhsu",   OP_MULHSU, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33);
        send("div_neg",  OP_DIV,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33);
        send("rem_neg",  OP_REM,    32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33);
        send("div_negb", OP_DIV,    32'd7,         32'hFFFF_FFFE, 32'hFFFF_FFFD, 33);
        send("rem_negb", OP_REM,    32'd7,         32'hFFFF_FFFE, 32'd1,         33);
        send("divu",     OP_DIVU,   32'd100,       32'd7,         32'd14,        33);
        send("remu",     OP_REMU,   32'd100,       32'd7,         32'd2,         33);
        send("divu_z",   OP_DIVU,   32'd7,         32'd0,         32'hFFFF_FFFF, 1);
        send("rem_z",    OP_REM,    32'd7,         32'd0,         32'd7,         1);
        send("div_ovf",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        send("rem_ovf",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1);
        drain();

        // Back-to-back single-cycle ops with the consumer always ready.
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            in_valid_i = 1'b1; op_i = OP_ADD; a_i = 32'(i * 16); b_i = 32'd1;
            @(negedge clk);
            chk("b2b_in_ready", 32'(in_ready_o), 32'd1);
            push_exp("b2b_add", 32'(i * 16 + 1), 1);
            @(posedge clk); #1;
        end
        in_valid_i = 1'b0;
        drain();

        // Backpressure: result held for 5 cycles, next op taken the cycle ready returns.
        out_ready_i = 1'b0;
        send("bp_add", OP_ADD, 32'd5, 32'd6, 32'd11, 1);
        in_valid_i = 1'b1; op_i = OP_SUB; a_i = 32'd10; b_i = 32'd3;
        repeat (5) begin
            @(negedge clk);
            chk("bp_in_ready", 32'(in_ready_o), 32'd0);
            chk("bp_out_valid", 32'(out_valid_o), 32'd1);
            chk("bp_result", result_o, 32'd11);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
        @(negedge clk);
        chk("bp_accept_same_cycle", 32'(in_ready_o), 32'd1);
        push_exp("bp_sub", 32'd7, 1);
        @(posedge clk); #1;
        in_valid_i = 1'b0;
        drain();

        // Flush partway through a divide: nothing may come out.
        send("divu_flush", OP_DIVU, 32'd1000, 32'd3, 32'd0, 0, 1'b0);
        repeat (9) @(posedge clk);
        @(negedge clk);
        chk("flush_busy_before", 32'(busy_o), 32'd1);
        @(posedge clk); #1;
        flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        @(negedge clk);
        chk("flush_in_ready", 32'(in_ready_o), 32'd1);
        chk("flush_busy_after", 32'(busy_o), 32'd0);
        // An op presented together with flush must be dropped.
        @(posedge clk); #1;
        flush_i = 1'b1; in_valid_i = 1'b1; op_i = OP_ADD; a_i = 32'd1; b_i = 32'd1;
        @(posedge clk); #1;
        flush_i = 1'b0; in_valid_i = 1'b0;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) cnt++;
        end
        chk("flush_no_valid", 32'(cnt), 32'd0);

        // Async reset during a multiply clears everything at once.
        send("pre_rst_add", OP_ADD, 32'd1, 32'd2, 32'd3, 1);
        drain();
        send("mul_rst", OP_MUL, 32'd3, 32'd5, 32'd0, 0, 1'b0);
        repeat (5) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", 32'(out_valid_o), 32'd0);
        chk("midrst_result", result_o, 32'd0);
        chk("midrst_busy", 32'(busy_o), 32'd0);
        @(posedge clk); #1 rst_n = 1'b1;
        cnt = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid_o) cnt++;
        end
        chk("midrst_no_valid", 32'(cnt), 32'd0);
        send("post_rst_mulhu", OP_MULHU, 32'h0001_0000, 32'h0001_0000, 32'd1, 33);
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
